// File: rtl/wdt_a_if.sv
// CPU memory-bus view of the watchdog: address, write data/strobes and the
// read data this peripheral ORs onto MDBin.
interface wdt_a_if;
  logic [15:0] MAB;
  logic [15:0] MDBwr;
  logic        MW;
  logic        BW;
  logic [15:0] MDBrd;

  modport master (output MAB, output MDBwr, output MW, output BW, input MDBrd);
  modport slave  (input MAB, input MDBwr, input MW, input BW, output MDBrd);
endinterface

// File: rtl/wdt_a.sv
// Watchdog / interval timer at WDTCTL: password-protected control register,
// 32-bit MCLK counter, PUC request on expiry or violation, IFG in interval mode.
module wdt_a #(
  parameter logic [15:0] ADDR    = 16'h015C,
  parameter logic [15:0] RST_VAL = 16'h6904
) (
  input  logic      MCLK,
  input  logic      reset,
  wdt_a_if.slave    bus,
  output logic      PUC,
  output logic      IRQ,
  input  logic      IACK
);

  localparam logic [7:0] PASSWORD = 8'h5A;
  localparam logic [7:0] RD_HIGH  = RST_VAL[15:8];
  localparam int TC_LOG2 [8] = '{31, 27, 23, 19, 15, 13, 9, 6};

  logic [7:0]  ctl_reg, ctl_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        ifg_reg, ifg_next;
  logic        puc_reg, puc_next;

  logic [31:0] term_tbl [8];
  logic [31:0] term;
  logic        hold, tmsel;
  logic [2:0]  is_sel;
  logic        sel, wr, valid_wr, viol, wr_clr, wr_hold, expire;

  // Terminal value N-1 for each IS setting
  for (genvar gi = 0; gi < 8; gi++) begin : g_term
    assign term_tbl[gi] = (32'd1 << TC_LOG2[gi]) - 32'd1;
  end

  assign hold   = ctl_reg[7];
  assign tmsel  = ctl_reg[4];
  assign is_sel = ctl_reg[2:0];
  assign term   = term_tbl[is_sel];

  assign sel      = (bus.MAB[15:1] == ADDR[15:1]);
  assign wr       = sel & bus.MW;
  assign valid_wr = wr & ~bus.BW & (bus.MDBwr[15:8] == PASSWORD);
  assign viol     = wr & ~valid_wr;
  assign wr_clr   = valid_wr & bus.MDBwr[3];
  assign wr_hold  = valid_wr & bus.MDBwr[7];

  // A clearing or freezing write in the terminal cycle cancels that expiry
  assign expire = ~hold & (cnt_reg == term) & ~wr_clr & ~wr_hold;

  always_comb begin
    ctl_next = ctl_reg;
    cnt_next = cnt_reg;
    ifg_next = ifg_reg;
    puc_next = 1'b0;

    if (valid_wr)
      ctl_next = {bus.MDBwr[7:4], 1'b0, bus.MDBwr[2:0]};

    if (expire)
      cnt_next = 32'd0;
    else if (~hold)
      cnt_next = cnt_reg + 32'd1;
    if (wr_clr)
      cnt_next = 32'd0;

    // Set has priority over acknowledge
    ifg_next = (expire & tmsel) | (ifg_reg & ~IACK);

    // The pulse is never stretched by sources arriving while it is high
    puc_next = ~puc_reg & (viol | (expire & ~tmsel));

    // Self-applied power-up clear; IFG deliberately survives it
    if (puc_reg) begin
      ctl_next = RST_VAL[7:0];
      cnt_next = 32'd0;
    end
  end

  always_ff @(posedge MCLK or negedge reset) begin
    if (!reset) begin
      ctl_reg <= RST_VAL[7:0];
      cnt_reg <= 32'd0;
      ifg_reg <= 1'b0;
      puc_reg <= 1'b0;
    end else begin
      ctl_reg <= ctl_next;
      cnt_reg <= cnt_next;
      ifg_reg <= ifg_next;
      puc_reg <= puc_next;
    end
  end

  assign PUC = puc_reg;
  assign IRQ = ifg_reg;

  // Zero-latency read path for the CPU's same-cycle MDBin sampling
  always_comb begin
    bus.MDBrd = 16'h0000;
    if (sel) begin
      if (!bus.BW)
        bus.MDBrd = {RD_HIGH, ctl_reg};
      else if (bus.MAB[0])
        bus.MDBrd = {8'h00, RD_HIGH};
      else
        bus.MDBrd = {8'h00, ctl_reg};
    end
  end

endmodule

// File: tb/tb_wdt_a.sv
// Directed bench for wdt_a: reset view, expiry timing, password violations,
// hold, simultaneous events, interval IRQ/IACK and asynchronous reset.
module tb_wdt_a;

  logic MCLK = 1'b0;
  logic reset = 1'b1;
  logic IACK = 1'b0;
  logic PUC, IRQ;
  int   vectors = 0;
  int   miscompares = 0;

  wdt_a_if bus ();

  wdt_a dut (
    .MCLK  (MCLK),
    .reset (reset),
    .bus   (bus),
    .PUC   (PUC),
    .IRQ   (IRQ),
    .IACK  (IACK)
  );

  always #5 MCLK = ~MCLK;

  task automatic tick;
    @(posedge MCLK);
    @(negedge MCLK);
  endtask

  task automatic idle_bus;
    bus.MAB   = 16'h015C;
    bus.MDBwr = 16'h0000;
    bus.MW    = 1'b0;
    bus.BW    = 1'b0;
    #1;
  endtask

  task automatic drive_wr(input logic [15:0] a, input logic [15:0] d, input logic bw);
    bus.MAB   = a;
    bus.MDBwr = d;
    bus.BW    = bw;
    bus.MW    = 1'b1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic bw);
    drive_wr(a, d, bw);
    tick;
    idle_bus;
  endtask

  task automatic read_at(input logic [15:0] a, input logic bw);
    bus.MAB = a;
    bus.BW  = bw;
    bus.MW  = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    idle_bus;
    @(negedge MCLK);
    vectors++; if (PUC !== 1'b0) begin miscompares++; $display("FAIL reset_puc: got %b want 0", PUC); end
    vectors++; if (IRQ !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b want 0", IRQ); end
    read_at(16'h015C, 1'b0);
    vectors++; if (bus.MDBrd !== 16'h6904) begin miscompares++; $display("FAIL rd_word_15C: got %h want 6904", bus.MDBrd); end
    read_at(16'h015D, 1'b1);
    vectors++; if (bus.MDBrd !== 16'h0069) begin miscompares++; $display("FAIL rd_byte_15D: got %h want 0069", bus.MDBrd); end
    read_at(16'h015C, 1'b1);
    vectors++; if (bus.MDBrd !== 16'h0004) begin miscompares++; $display("FAIL rd_byte_15C: got %h want 0004", bus.MDBrd); end
    read_at(16'h015D, 1'b0);
    vectors++; if (bus.MDBrd !== 16'h6904) begin miscompares++; $display("FAIL rd_word_15D: got %h want 6904", bus.MDBrd); end
    read_at(16'h015E, 1'b0);
    vectors++; if (bus.MDBrd !== 16'h0000) begin miscompares++; $display("FAIL rd_unsel_15E: got %h want 0000", bus.MDBrd); end
    idle_bus;
    $display("test_reset: done");
  endtask

  task automatic test_default_expiry;
    int first = 0;
    int pucs = 0;
    reset = 1'b1;
    for (int n = 1; n <= 32769; n++) begin
      tick;
      if (PUC === 1'b1) begin
        if (first == 0) first = n;
        pucs++;
      end
    end
    vectors++; if (first !== 32768) begin miscompares++; $display("FAIL default_puc_cycle: got %0d want 32768", first); end
    vectors++; if (pucs !== 1) begin miscompares++; $display("FAIL default_puc_width: got %0d want 1", pucs); end
    vectors++; if (bus.MDBrd !== 16'h6904) begin miscompares++; $display("FAIL default_ctl_after_puc: got %h want 6904", bus.MDBrd); end
    // IS=7 without CNTCL: only a freshly restarted counter expires 63 edges later
    do_write(16'h015C, 16'h5A07, 1'b0);
    first = 0;
    for (int n = 1; n <= 100; n++) begin
      tick;
      if (PUC === 1'b1 && first == 0) first = n;
    end
    vectors++; if (first !== 63) begin miscompares++; $display("FAIL restart_after_puc: got %0d want 63", first); end
    $display("test_default_expiry: done");
  endtask

  task automatic test_violation;
    do_write(16'h015C, 16'h5A8F, 1'b0);
    vectors++; if (bus.MDBrd !== 16'h6987) begin miscompares++; $display("FAIL viol_setup_rd: got %h want 6987", bus.MDBrd); end
    do_write(16'h015C, 16'h1234, 1'b0);
    vectors++; if (PUC !== 1'b1) begin miscompares++; $display("FAIL viol_word_puc: got %b want 1", PUC); end
    vectors++; if (bus.MDBrd !== 16'h6987) begin miscompares++; $display("FAIL viol_ctl_unchanged: got %h want 6987", bus.MDBrd); end
    tick;
    vectors++; if (PUC !== 1'b0) begin miscompares++; $display("FAIL viol_word_puc_end: got %b want 0", PUC); end
    vectors++; if (bus.MDBrd !== 16'h6904) begin miscompares++; $display("FAIL viol_ctl_after_puc: got %h want 6904", bus.MDBrd); end
    do_write(16'h015D, 16'h5A5A, 1'b1);
    vectors++; if (PUC !== 1'b1) begin miscompares++; $display("FAIL viol_byte_puc: got %b want 1", PUC); end
    tick;
    vectors++; if (PUC !== 1'b0) begin miscompares++; $display("FAIL viol_byte_puc_end: got %b want 0", PUC); end
    drive_wr(16'h015C, 16'h1234, 1'b0);
    tick;
    vectors++; if (PUC !== 1'b1) begin miscompares++; $display("FAIL b2b_first: got %b want 1", PUC); end
    tick;
    vectors++; if (PUC !== 1'b0) begin miscompares++; $display("FAIL b2b_no_extend: got %b want 0", PUC); end
    idle_bus;
    $display("test_violation: done");
  endtask

  task automatic test_hold;
    int first = 0;
    logic [15:0] rd_hold = 16'h0000;
    do_write(16'h015C, 16'h5A0F, 1'b0);
    for (int n = 1; n <= 600; n++) begin
      if (n == 30)  drive_wr(16'h015C, 16'h5A87, 1'b0);
      if (n == 500) drive_wr(16'h015C, 16'h5A07, 1'b0);
      tick;
      idle_bus;
      if (n == 400) rd_hold = bus.MDBrd;
      if (PUC === 1'b1 && first == 0) first = n;
    end
    vectors++; if (rd_hold !== 16'h6987) begin miscompares++; $display("FAIL hold_rd: got %h want 6987", rd_hold); end
    vectors++; if (first !== 534) begin miscompares++; $display("FAIL hold_resume_puc: got %0d want 534", first); end
    $display("test_hold: done");
  endtask

  task automatic test_suppress;
    int first = 0;
    do_write(16'h015C, 16'h5A0F, 1'b0);
    for (int n = 1; n <= 300; n++) begin
      if (n == 64)  drive_wr(16'h015C, 16'h5A87, 1'b0);
      if (n == 200) drive_wr(16'h015C, 16'h5A0F, 1'b0);
      tick;
      idle_bus;
      if (PUC === 1'b1 && first == 0) first = n;
    end
    vectors++; if (first !== 264) begin miscompares++; $display("FAIL hold_on_expiry: got %0d want 264", first); end
    $display("test_suppress: done");
  endtask

  task automatic test_cntcl_on_expiry;
    int first = 0;
    int pucs = 0;
    do_write(16'h015C, 16'h5A0F, 1'b0);
    for (int n = 1; n <= 130; n++) begin
      if (n == 64) drive_wr(16'h015C, 16'h5A0F, 1'b0);
      tick;
      idle_bus;
      if (PUC === 1'b1) begin
        if (first == 0) first = n;
        pucs++;
      end
    end
    vectors++; if (first !== 128) begin miscompares++; $display("FAIL cntcl_on_expiry: got %0d want 128", first); end
    vectors++; if (pucs !== 1) begin miscompares++; $display("FAIL cntcl_puc_count: got %0d want 1", pucs); end
    $display("test_cntcl_on_expiry: done");
  endtask

  task automatic test_kick;
    int first = 0;
    do_write(16'h015C, 16'h5A0D, 1'b0);
    for (int n = 1; n <= 29300; n++) begin
      if (n % 7000 == 0 && n <= 21000) drive_wr(16'h015C, 16'h5A0D, 1'b0);
      tick;
      idle_bus;
      if (PUC === 1'b1 && first == 0) first = n;
    end
    vectors++; if (first !== 29192) begin miscompares++; $display("FAIL kick_puc_cycle: got %0d want 29192", first); end
    $display("test_kick: done");
  endtask

  task automatic test_interval;
    logic [260:0] irq_hist;
    int pucs = 0;
    int idx [8] = '{63, 64, 65, 127, 128, 192, 193, 256};
    logic exp_irq [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    irq_hist = '0;
    do_write(16'h015C, 16'h5A1F, 1'b0);
    for (int n = 1; n <= 260; n++) begin
      IACK = (n == 65 || n == 192 || n == 193);
      tick;
      IACK = 1'b0;
      irq_hist[n] = IRQ;
      if (PUC === 1'b1) pucs++;
    end
    for (int k = 0; k < 8; k++) begin
      vectors++;
      if (irq_hist[idx[k]] !== exp_irq[k]) begin
        miscompares++;
        $display("FAIL irq_at_%0d: got %b want %b", idx[k], irq_hist[idx[k]], exp_irq[k]);
      end
    end
    vectors++; if (pucs !== 0) begin miscompares++; $display("FAIL interval_no_puc: got %0d want 0", pucs); end
    $display("test_interval: done");
  endtask

  task automatic test_ifg_and_async_reset;
    do_write(16'h015C, 16'h1234, 1'b0);
    vectors++; if (PUC !== 1'b1) begin miscompares++; $display("FAIL ifg_puc: got %b want 1", PUC); end
    tick;
    vectors++; if (IRQ !== 1'b1) begin miscompares++; $display("FAIL ifg_kept_over_puc: got %b want 1", IRQ); end
    do_write(16'h015C, 16'h5A8F, 1'b0);
    do_write(16'h015C, 16'h1234, 1'b0);
    vectors++; if (PUC !== 1'b1) begin miscompares++; $display("FAIL async_pre_puc: got %b want 1", PUC); end
    reset = 1'b0;
    #1;
    vectors++; if (PUC !== 1'b0) begin miscompares++; $display("FAIL async_puc_clear: got %b want 0", PUC); end
    vectors++; if (IRQ !== 1'b0) begin miscompares++; $display("FAIL async_irq_clear: got %b want 0", IRQ); end
    vectors++; if (bus.MDBrd !== 16'h6904) begin miscompares++; $display("FAIL async_ctl_clear: got %h want 6904", bus.MDBrd); end
    @(negedge MCLK);
    reset = 1'b1;
    tick;
    $display("test_ifg_and_async_reset: done");
  endtask

  initial begin
    test_reset;
    test_default_expiry;
    test_violation;
    test_hold;
    test_suppress;
    test_cntcl_on_expiry;
    test_kick;
    test_interval;
    test_ifg_and_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
